// File: rtl/contador_regressivo_pkg.sv
// contador_regressivo_pkg: shared FSM encoding and prescaler width helper
package contador_regressivo_pkg;
  typedef enum logic {ST_COUNT = 1'b0, ST_HALT = 1'b1} state_t;
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++)
      if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/contador_regressivo_if.sv
// contador_regressivo_if: control and status bundle of the down-counter
interface contador_regressivo_if #(parameter int WIDTH = 3);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             one_shot;
  logic [WIDTH-1:0] S;
  logic             tc;
  logic             done;
  modport master(output enable, load, load_value, one_shot, input S, tc, done);
  modport slave(input enable, load, load_value, one_shot, output S, tc, done);
endinterface

// File: rtl/contador_regressivo_divisor_tick.sv
// divisor_tick: prescaler that emits one tick every PRESCALE enabled cycles
module divisor_tick import contador_regressivo_pkg::*; #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int PW = clog2(PRESCALE) > 0 ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
  assign tick = enable && pcnt_q == LAST;
  always_comb pcnt_d = clear ? '0 : !enable ? pcnt_q : tick ? '0 : pcnt_q + PW'(1);
  always_ff @(posedge clock or posedge reset)
    if (reset) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/contador_regressivo.sv
// contador_regressivo: loadable modulo down-counter with wrap or one-shot halt
module contador_regressivo import contador_regressivo_pkg::*; #(
  parameter int WIDTH    = 3,
  parameter int MAX      = 4,
  parameter int PRESCALE = 1
) (
  input logic            clock,
  input logic            reset,
  contador_regressivo_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             tc_q, tc_d, done_q, done_d, tick;
  divisor_tick #(.PRESCALE(PRESCALE)) u_div (
    .clock, .reset, .clear(bus.load), .enable(bus.enable && state_q == ST_COUNT), .tick
  );
  always_comb begin
    s_d = s_q;
    state_d = state_q;
    tc_d = 1'b0;
    done_d = done_q;
    if (bus.load) begin
      s_d = bus.load_value > MAXV ? MAXV : bus.load_value;
      state_d = ST_COUNT;
      done_d = 1'b0;
    end else if (tick) begin
      // from 0 only a wrap restarts at MAX; one-shot keeps 0 and halts
      s_d = s_q > ONE ? s_q - ONE : (s_q == ONE || bus.one_shot) ? '0 : MAXV;
      tc_d = s_q == ONE;
      if (s_q <= ONE && bus.one_shot) begin
        state_d = ST_HALT;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s_q <= MAXV;
      state_q <= ST_COUNT;
      tc_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s_q <= s_d;
      state_q <= state_d;
      tc_q <= tc_d;
      done_q <= done_d;
    end
  assign bus.S = s_q;
  assign bus.tc = tc_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_contador_regressivo.sv
// tb_contador_regressivo: directed and random checks of two prescale variants against a model
module tb_contador_regressivo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  contador_regressivo_if #(.WIDTH(3)) b1 ();
  contador_regressivo_if #(.WIDTH(3)) b3 ();
  contador_regressivo #(.WIDTH(3), .MAX(4), .PRESCALE(1)) dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
  contador_regressivo #(.WIDTH(3), .MAX(4), .PRESCALE(3)) dut3 (.clock(clock), .reset(reset), .bus(b3.slave));
  int n_chk = 0, n_pass = 0;
  int m_s[2], m_cnt[2], ps[2];
  bit m_halt[2], m_tc[2];
  string phase;
  int seq[12] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3, 2};
  int pat_en[5] = '{1, 1, 0, 0, 1};
  int pat_s3[5] = '{4, 4, 4, 4, 3};
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s[k] = 4; m_cnt[k] = 0; m_halt[k] = 0; m_tc[k] = 0;
    end
  endtask
  task automatic model_edge(input bit en, input bit ld, input int lv, input bit os);
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0;
      if (ld) begin
        m_s[k] = lv > 4 ? 4 : lv; m_cnt[k] = 0; m_halt[k] = 0;
      end else if (en && !m_halt[k]) begin
        if (m_cnt[k] == ps[k] - 1) begin
          m_cnt[k] = 0;
          if (m_s[k] > 1) m_s[k] = m_s[k] - 1;
          else if (m_s[k] == 1) begin
            m_s[k] = 0; m_tc[k] = 1; m_halt[k] = os;
          end else if (os) m_halt[k] = 1;
          else m_s[k] = 4;
        end else m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask
  task automatic check_all();
    check({phase, ".S1"}, int'(b1.S), m_s[0]);
    check({phase, ".tc1"}, int'(b1.tc), int'(m_tc[0]));
    check({phase, ".done1"}, int'(b1.done), int'(m_halt[0]));
    check({phase, ".S3"}, int'(b3.S), m_s[1]);
    check({phase, ".tc3"}, int'(b3.tc), int'(m_tc[1]));
    check({phase, ".done3"}, int'(b3.done), int'(m_halt[1]));
  endtask
  task automatic drive(input bit en, input bit ld, input int lv, input bit os);
    b1.enable = en; b1.load = ld; b1.load_value = 3'(lv); b1.one_shot = os;
    b3.enable = en; b3.load = ld; b3.load_value = 3'(lv); b3.one_shot = os;
  endtask
  task automatic step(input bit en, input bit ld, input int lv, input bit os);
    drive(en, ld, lv, os);
    @(posedge clock);
    model_edge(en, ld, lv, os);
    #1;
    check_all();
  endtask
  initial begin
    ps[0] = 1; ps[1] = 3;
    drive(0, 0, 0, 0);
    model_reset();
    phase = "reset";
    #12;
    check_all();
    reset = 1'b0;
    phase = "async_reset";
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("pre_reset.S1", int'(b1.S), 2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
    phase = "wrap";
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      check("wrap_seq.S1", int'(b1.S), seq[i]);
      check("wrap_seq.tc1", int'(b1.tc), seq[i] == 0 ? 1 : 0);
    end
    phase = "one_shot";
    step(1, 1, 4, 1);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 1);
    check("halt.S1", int'(b1.S), 0);
    check("halt.done1", int'(b1.done), 1);
    step(1, 1, 3, 1);
    check("reload.S1", int'(b1.S), 3);
    check("reload.done1", int'(b1.done), 0);
    phase = "clamp";
    step(1, 1, 7, 0);
    check("clamp.S1", int'(b1.S), 4);
    step(1, 1, 2, 0);
    check("load_vs_tick.S1", int'(b1.S), 2);
    phase = "prescale";
    step(0, 1, 4, 0);
    for (int i = 0; i < 5; i++) begin
      step(pat_en[i][0], 0, 0, 0);
      check("prescale.S3", int'(b3.S), pat_s3[i]);
    end
    phase = "load_zero";
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("zero_wrap.S1", int'(b1.S), 4);
    check("zero_wrap.tc1", int'(b1.tc), 0);
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    check("zero_halt.S1", int'(b1.S), 0);
    check("zero_halt.done1", int'(b1.done), 1);
    check("zero_halt.tc1", int'(b1.tc), 0);
    phase = "random";
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(15) == 0, int'($urandom_range(7)), $urandom_range(7) < 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
